// File: rtl/cntr8b_down_timer.sv
// rtl/cntr8b_down_timer.sv - loadable down-counter/timer with one-cycle terminal-count pulse
// Optional feature macro: CNTR8B_AUTO_RELOAD_EN (periodic reload from the last loaded value)
module cntr8b_down_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             load_hs;

`ifdef CNTR8B_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   assign load_ready = (state_q == S_IDLE) && !abort && !rst;
   assign load_hs    = load_valid && load_ready;
   assign count      = count_q;
   assign busy       = (state_q == S_RUN);
   assign tc         = (state_q == S_DONE);

   // Next-state and next-count selection; abort wins over counting and reload.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
`ifdef CNTR8B_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (load_hs) begin
               count_d = load_value;
               state_d = (load_value != ZERO) ? S_RUN : S_DONE;
`ifdef CNTR8B_AUTO_RELOAD_EN
               reload_d = load_value;
`endif
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               count_d = ZERO;
            end else if (en) begin
               if (count_q > ONE) begin
                  count_d = count_q - ONE;
               end else begin
                  // RUN is never entered with zero, so this is the 1 -> 0 step.
                  count_d = ZERO;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            count_d = ZERO;
            if (abort) begin
               state_d = S_IDLE;
`ifdef CNTR8B_AUTO_RELOAD_EN
            end else if (reload_q == ONE) begin
               // A period of one cycle keeps tc high continuously.
               state_d = S_DONE;
            end else if (reload_q != ZERO) begin
               // The DONE cycle is the first cycle of the next period, so
               // resume one step down to keep tc exactly reload cycles apart.
               state_d = S_RUN;
               count_d = reload_q - ONE;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = ZERO;
         end
      endcase
   end

   // State, count and reload registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= ZERO;
`ifdef CNTR8B_AUTO_RELOAD_EN
         reload_q <= ZERO;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
`ifdef CNTR8B_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

endmodule
